// File: rtl/wrr_mtx_arb.sv
// rtl/wrr_mtx_arb.sv - weighted least-recently-granted matrix arbiter with lock
module wrr_mtx_arb #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            upd,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_id
);

    localparam logic [WW-1:0] CNT_MAX = {WW{1'b1}};

    // prio[i][j] = 1 means requester i beats requester j; diagonal unused
    logic [N-1:0]  prio     [N];
    logic [N-1:0]  prio_eff [N];
    logic [WW-1:0] cnt;
    logic [WW-1:0] wt_q;

    logic          own;
    logic          hold;
    logic          release_upd;
    logic [N-1:0]  win;
    logic [IW-1:0] win_id;

    always_comb begin
        own         = |gnt;
        hold        = own && req[gnt_id] && (lock[gnt_id] || (cnt < wt_q));
        release_upd = own && !hold && upd;

        // The releasing owner drops to lowest priority before the next winner is picked
        for (int i = 0; i < N; i++) begin
            prio_eff[i] = prio[i];
        end
        if (release_upd) begin
            for (int j = 0; j < N; j++) begin
                if (j != int'(gnt_id)) begin
                    prio_eff[gnt_id][j] = 1'b0;
                    prio_eff[j][gnt_id] = 1'b1;
                end
            end
        end

        win = '0;
        for (int i = 0; i < N; i++) begin
            win[i] = req[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && req[j] && prio_eff[j][i]) begin
                    win[i] = 1'b0;
                end
            end
        end

        win_id = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_id = win_id | IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            cnt     <= '0;
            wt_q    <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    prio[i][j] <= (i < j);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                prio[i] <= prio_eff[i];
            end
            if (hold) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + WW'(1);
                end
            end else begin
                gnt     <= win;
                gnt_vld <= |win;
                gnt_id  <= win_id;
                cnt     <= '0;
                if (|win) begin
                    wt_q <= weight[win_id*WW +: WW];
                end
            end
        end
    end

endmodule

// File: tb/tb_wrr_mtx_arb.sv
// tb/tb_wrr_mtx_arb.sv - directed self-checking bench for wrr_mtx_arb
module tb_wrr_mtx_arb;

    logic        clk;
    logic        rstn;
    logic        upd;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic [1:0]  gnt_id;

    int total;
    int bad;

    wrr_mtx_arb #(.N(4), .WW(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .upd     (upd),
        .req     (req),
        .lock    (lock),
        .weight  (weight),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = '0; lock = '0; upd = 1'b1; weight = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset_rr();
        logic [3:0] e   [5];
        logic [1:0] eid [5];
        e   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        eid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rstn = 1'b0; req = 4'b1111; lock = '0; upd = 1'b1; weight = '0;
        @(negedge clk);
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0000_0_00) begin
            bad++;
            $display("FAIL reset: got gnt=%b vld=%b id=%0d, want 0000/0/0", gnt, gnt_vld, gnt_id);
        end
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, gnt_vld, gnt_id} !== {e[c], 1'b1, eid[c]}) begin
                bad++;
                $display("FAIL rr c%0d: got gnt=%b vld=%b id=%0d, want gnt=%b vld=1 id=%0d",
                         c, gnt, gnt_vld, gnt_id, e[c], eid[c]);
            end
        end
    endtask

    task automatic test_weights();
        logic [3:0] e   [10];
        logic [1:0] eid [10];
        e   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        eid = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
        do_reset();
        weight = 16'h0002;
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, gnt_vld, gnt_id} !== {e[c], 1'b1, eid[c]}) begin
                bad++;
                $display("FAIL weight c%0d: got gnt=%b vld=%b id=%0d, want gnt=%b vld=1 id=%0d",
                         c, gnt, gnt_vld, gnt_id, e[c], eid[c]);
            end
            if (c == 6) weight = 16'h0005;
        end
    endtask

    task automatic test_lock();
        do_reset();
        req = 4'b0011; lock = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, gnt_vld, gnt_id} !== 7'b0001_1_00) begin
                bad++;
                $display("FAIL lock c%0d: got gnt=%b vld=%b id=%0d, want 0001/1/0", c, gnt, gnt_vld, gnt_id);
            end
        end
        lock = 4'b0000;
        @(negedge clk);
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0010_1_01) begin
            bad++;
            $display("FAIL unlock: got gnt=%b vld=%b id=%0d, want 0010/1/1", gnt, gnt_vld, gnt_id);
        end
    endtask

    task automatic test_frozen();
        logic [3:0] e [3];
        e = '{4'b0100, 4'b0010, 4'b0100};
        do_reset();
        upd = 1'b0; req = 4'b0110;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, gnt_id} !== 6'b0010_01) begin
                bad++;
                $display("FAIL frozen c%0d: got gnt=%b id=%0d, want 0010/1", c, gnt, gnt_id);
            end
        end
        upd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (gnt !== e[c]) begin
                bad++;
                $display("FAIL thaw c%0d: got gnt=%b, want %b", c, gnt, e[c]);
            end
        end
    endtask

    task automatic test_drop_idle();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, gnt_vld, gnt_id} !== 7'b0100_1_10) begin
                bad++;
                $display("FAIL hold2 c%0d: got gnt=%b vld=%b id=%0d, want 0100/1/2", c, gnt, gnt_vld, gnt_id);
            end
        end
        req = 4'b0000;
        @(negedge clk);
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0000_0_00) begin
            bad++;
            $display("FAIL idle: got gnt=%b vld=%b id=%0d, want 0000/0/0", gnt, gnt_vld, gnt_id);
        end
        req = 4'b0101;
        @(negedge clk);
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0001_1_00) begin
            bad++;
            $display("FAIL after_idle: got gnt=%b vld=%b id=%0d, want 0001/1/0", gnt, gnt_vld, gnt_id);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0001; weight = 16'h0700;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL pre0: got gnt=%b, want 0001", gnt);
        end
        req = 4'b0100;
        @(negedge clk);
        total++;
        if ({gnt, gnt_id} !== 6'b0100_10) begin
            bad++;
            $display("FAIL own2: got gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
        end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0000_0_00) begin
            bad++;
            $display("FAIL async_rst: got gnt=%b vld=%b id=%0d, want 0000/0/0", gnt, gnt_vld, gnt_id);
        end
        #1 rstn = 1'b1;
        req = 4'b1111; weight = '0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL rst_hold: got gnt=%b, want 0000", gnt);
        end
        @(negedge clk);
        total++;
        if ({gnt, gnt_vld, gnt_id} !== 7'b0001_1_00) begin
            bad++;
            $display("FAIL prio_restore: got gnt=%b vld=%b id=%0d, want 0001/1/0", gnt, gnt_vld, gnt_id);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        clk = 1'b0; rstn = 1'b0; upd = 1'b1; req = '0; lock = '0; weight = '0;
        test_reset_rr();
        test_weights();
        test_lock();
        test_frozen();
        test_drop_idle();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wrr_mtx_arb.md
# wrr_mtx_arb

Parametrised weighted matrix arbiter, successor to the basic `mtx_arb`. It grants one of N requesters using a least-recently-granted priority matrix. It adds per-requester burst weights, a lock input for multi-cycle ownership, and registered one-hot, index and valid grant outputs. It sits in front of shared resources such as a bus slave port or a memory bank, where clients need bounded multi-cycle tenure.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `WW`, default 4: weight and credit-counter width.
- `IW`, default `$clog2(N)`: grant index width.

- `clk`  in  1: clock, all state on the rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `upd`  in  1: 1 = the priority matrix updates on grant release; 0 = the matrix is frozen.
- `req`  in  N: request vector, level-sensitive.
- `lock`  in  N: `lock[i]` = owner i holds its grant regardless of credits.
- `weight`  in  N*WW: `weight[i*WW +: WW]` = extra cycles requester i may hold its grant.
- `gnt`  out  N: registered one-hot grant.
- `gnt_vld`  out  1: `|gnt`, registered.
- `gnt_id`  out  IW: index of the set `gnt` bit; 0 when `gnt_vld` = 0.

## Operation
- **Priority matrix.**
  - `prio[i][j]` = 1 means i beats j, for i≠j only.
  - Invariant: `prio[j][i]` = ~`prio[i][j]`.
  - Reset value: `prio[i][j]` = 1 for all i<j, so index 0 has the highest priority.
- **Winner function.** For a request vector r and matrix P, i wins iff `r[i]` and no j≠i has `r[j] & P[j][i]`. The result is one-hot or zero.
- **States.** IDLE when `gnt` = 0; OWN(k) when `gnt[k]` = 1.
- **Hold condition in OWN(k).** `req[k] & (lock[k] | cnt < wt_q)`.
  - `cnt` is a WW-bit per-grant cycle counter.
  - `wt_q` is `weight[k]` sampled on the edge that issued the grant. Later changes to `weight` are ignored for the current grant.
  - On hold: `gnt` is unchanged and `cnt` increments, saturating at 2^WW−1.
- **Release in OWN(k).** Release happens when the hold condition is false.
  - If `upd` = 1, on the same edge k becomes lowest priority: `prio[k][j]` ← 0 and `prio[j][k]` ← 1 for all j≠k.
  - The next grant is winner(`req`, P′), where P′ is the matrix in effect after this edge: updated if `upd` = 1, otherwise unchanged.
  - Hand-over has no idle cycle.
  - If k is the only requester, it may be re-granted. This counts as a new grant: `cnt` ← 0 and `wt_q` is resampled.
- **IDLE.** The next grant is winner(`req`, P). The matrix does not change.
- **New grant.** `cnt` ← 0 and `wt_q` ← `weight[winner]`.
- **Lock.** `lock` is ignored for non-owners. A locked owner that drops `req` releases.
- **Frozen matrix.** With `upd` = 0, the same highest-priority requester may win repeatedly. This is intended starvation-by-configuration.

## Timing
- **Reset.** Asynchronous assertion immediately forces:
  - `gnt` = 0, `gnt_vld` = 0, `gnt_id` = 0;
  - `cnt` = 0, `wt_q` = 0;
  - `prio` = reset pattern.
  
  Arbitration resumes on the first rising edge after deassertion.
- **Grant latency.** `req` is sampled at edge t; `gnt` is visible after edge t, so there is 1 cycle from request to grant.
- **Release latency.** An owner that drops `req` before edge t still shows `gnt` during the preceding cycle. `gnt` moves at edge t.
- **Tenure.** With `lock` = 0 and `req` held, an owner keeps its grant for exactly `wt_q`+1 cycles.
- **Output consistency.** `gnt`, `gnt_vld` and `gnt_id` are all registered and always mutually consistent. No combinational path runs from inputs to outputs.

## Test plan
All scenarios use N=4, WW=4, `upd`=1, `lock`=0 and all weights 0 unless stated.

1. **Reset and round-robin.** Hold `rstn`=0 → `gnt`=0000, `gnt_vld`=0, `gnt_id`=0. Release reset, then `req`=1111 constant → `gnt` = 0001, 0010, 0100, 1000, 0001, one cycle each, with `gnt_id` = 0, 1, 2, 3, 0.
2. **Weights.** `weight[0]`=2, others 0, `req`=1111 → `gnt`=0001 for 3 cycles, then 0010, 0100, 1000 one cycle each, then 0001 for 3 cycles. Changing `weight[0]` to 5 mid-tenure does not extend the current grant.
3. **Lock.** `req`=0011 with `lock[0]`=1 for 6 cycles → `gnt`=0001 for all 6 cycles. When `lock[0]` falls, `gnt`=0010 on the next edge.
4. **Frozen matrix.** `upd`=0, `req`=0110 → `gnt`=0010 continuously. Raise `upd`=1 → `gnt` alternates 0100, 0010, 0100, and so on.
5. **Drop and idle.** `req`=0100 for 2 cycles, then 0000 → `gnt`=0100 for 2 cycles, then 0000 with `gnt_vld`=0 after the next edge. Apply `req`=0101 → 0001 wins, because 2 became lowest priority.
6. **Reset mid-operation.** During OWN(2) with `weight[2]`=7, pulse `rstn` low between edges → `gnt`=0 immediately. After reset, `req`=1111 → 0001 first (priority restored).
